// File: rtl/alu_exec_mc.sv
// Multicycle execute unit: ALU-control decode merged with the ALU datapath,
// plus an iterative low-half MUL behind a valid/ready handshake.
module alu_exec_mc #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluOp,
  input  logic [2:0]       f3,
  input  logic             f7,
  input  logic             m,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             out_valid
);

  localparam int N   = WIDTH / MUL_BITS;
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
  } opsel_t;

  state_t           state, nextState;
  opsel_t           opSel;
  logic             accept;
  logic [WIDTH-1:0] aluRes;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] partial, accNext;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EXEC) || (state == DONE);
  assign shamt     = b[SHW-1:0];

  always_comb begin
    opSel = OP_ILL;
    case (aluOp)
      2'b00: opSel = OP_ADD;
      2'b01: opSel = OP_SUB;
      2'b10: begin
        if (m) begin
          opSel = (op && (f3 == 3'b000)) ? OP_MUL : OP_ILL;
        end else begin
          case (f3)
            3'b000: opSel = (op && f7) ? OP_SUB : OP_ADD;
            3'b001: opSel = OP_SLL;
            3'b010: opSel = OP_SLT;
            3'b011: opSel = OP_SLTU;
            3'b100: opSel = OP_XOR;
            3'b101: opSel = f7 ? OP_SRA : OP_SRL;
            3'b110: opSel = OP_OR;
            default: opSel = OP_AND;
          endcase
        end
      end
      default: opSel = OP_ILL;
    endcase
  end

  always_comb begin
    aluRes = '0;
    case (opSel)
      OP_ADD:  aluRes = a + b;
      OP_SUB:  aluRes = a - b;
      OP_SLL:  aluRes = a << shamt;
      OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: aluRes = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  aluRes = a ^ b;
      OP_SRL:  aluRes = a >> shamt;
      OP_SRA:  aluRes = $signed(a) >>> shamt;
      OP_OR:   aluRes = a | b;
      OP_AND:  aluRes = a & b;
      default: aluRes = '0;
    endcase
  end

  // One shift-and-add step: multiplicand times the low MUL_BITS of the multiplier.
  assign partial = mcand * WIDTH'(mplier[MUL_BITS-1:0]);
  assign accNext = acc + partial;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = (opSel == OP_MUL) ? MUL : EXEC;
      EXEC: nextState = IDLE;
      MUL:  if (cnt == '0) nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Single-cycle ops register at the accept edge so out_valid lines up with EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (opSel == OP_MUL) begin
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
              cnt    <= CW'(N - 1);
            end else if (opSel == OP_ILL) begin
              result  <= '0;
              zero    <= 1'b1;
              illegal <= 1'b1;
            end else begin
              result  <= aluRes;
              zero    <= (aluRes == '0);
              illegal <= 1'b0;
            end
          end
        end
        MUL: begin
          acc    <= accNext;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            result  <= accNext;
            zero    <= (accNext == '0);
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_mc.sv
// Directed, table-driven bench for alu_exec_mc (MUL_BITS=1 main DUT,
// MUL_BITS=4 secondary DUT for the short-latency MUL case).
module tb_alu_exec_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_valid4;
  logic [1:0]  aluOp;
  logic [2:0]  f3;
  logic        f7, m, op;
  logic [31:0] a, b;

  logic        in_ready, zero, illegal, out_valid;
  logic [31:0] result;
  logic        in_ready4, zero4, illegal4, out_valid4;
  logic [31:0] result4;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_exec_mc #(.WIDTH(32), .MUL_BITS(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .f3(f3), .f7(f7), .m(m), .op(op), .a(a), .b(b),
    .result(result), .zero(zero), .illegal(illegal), .out_valid(out_valid)
  );

  alu_exec_mc #(.WIDTH(32), .MUL_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .aluOp(aluOp), .f3(f3), .f7(f7), .m(m), .op(op), .a(a), .b(b),
    .result(result4), .zero(zero4), .illegal(illegal4), .out_valid(out_valid4)
  );

  typedef struct {
    logic [1:0]  aluOp;
    logic [2:0]  f3;
    logic        f7;
    logic        m;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
    logic        expZero;
    logic        expIll;
    int          expLat;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issues one op on the main DUT and waits (bounded) for its out_valid.
  task automatic applyStimulus(input logic [1:0] ao, input logic [2:0] ff3,
                               input logic ff7, input logic mm, input logic oo,
                               input logic [31:0] aa, input logic [31:0] bb,
                               output int lat, output logic busyReady);
    logic seen;
    @(negedge clk);
    aluOp = ao; f3 = ff3; f7 = ff7; m = mm; op = oo; a = aa; b = bb;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    busyReady = 1'b0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (in_ready) busyReady = 1'b1;
      if (out_valid) seen = 1'b1;
    end
  endtask

  initial begin
    int   lat;
    logic busyReady;
    int   pulses;
    int   i;

    vecs[0]  = '{2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1};
    vecs[1]  = '{2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1};
    vecs[2]  = '{2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1};
    vecs[3]  = '{2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1};
    vecs[4]  = '{2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1};
    vecs[5]  = '{2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1};
    vecs[6]  = '{2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'h21, 32'hC0000000, 1'b0, 1'b0, 1};
    vecs[7]  = '{2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'h21, 32'h40000000, 1'b0, 1'b0, 1};
    vecs[8]  = '{2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 32'd1, 32'h24, 32'h10, 1'b0, 1'b0, 1};
    vecs[9]  = '{2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1};
    vecs[10] = '{2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1};
    vecs[11] = '{2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
    vecs[12] = '{2'b11, 3'b000, 1'b0, 1'b0, 1'b1, 32'd4, 32'd4, 32'd0, 1'b1, 1'b1, 1};
    vecs[13] = '{2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd4, 32'd4, 32'd0, 1'b1, 1'b1, 1};
    vecs[14] = '{2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1};
    vecs[15] = '{2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 32'd4, 32'd4, 32'd0, 1'b1, 1'b1, 1};
    vecs[16] = '{2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1};
    vecs[17] = '{2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b0, 1'b0, 33};

    reset = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0;
    aluOp = 2'b00; f3 = 3'b000; f7 = 1'b0; m = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset zero", {31'd0, zero}, 32'd0);
    checkOutput("reset illegal", {31'd0, illegal}, 32'd0);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("in_ready after reset", {31'd0, in_ready}, 32'd1);

    for (i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].aluOp, vecs[i].f3, vecs[i].f7, vecs[i].m, vecs[i].op,
                    vecs[i].a, vecs[i].b, lat, busyReady);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d result", i), result, vecs[i].expResult);
      checkOutput($sformatf("v%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].expZero});
      checkOutput($sformatf("v%0d illegal", i), {31'd0, illegal}, {31'd0, vecs[i].expIll});
      checkOutput($sformatf("v%0d in_ready busy", i), {31'd0, busyReady}, 32'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d pulse width", i), {31'd0, out_valid}, 32'd0);
    end

    // Reset in the middle of a MUL: no completion, result cleared.
    @(negedge clk);
    aluOp = 2'b10; f3 = 3'b000; f7 = 1'b0; m = 1'b1; op = 1'b1;
    a = 32'hFFFFFFFF; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    reset = 1'b1;
    #1;
    checkOutput("midmul reset result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midmul in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midmul result", result, 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checkOutput("midmul no out_valid", 32'(pulses), 32'd0);

    // in_valid held high with operands changing while MUL runs.
    @(negedge clk);
    aluOp = 2'b10; f3 = 3'b000; f7 = 1'b0; m = 1'b1; op = 1'b1;
    a = 32'd7; b = 32'd6; in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    busyReady = 1'b0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      a = $urandom;
      b = $urandom;
    end
    checkOutput("hold mul latency", 32'(lat), 32'd33);
    checkOutput("hold mul result", result, 32'd42);
    aluOp = 2'b01; a = 32'd9; b = 32'd9;
    @(negedge clk);
    checkOutput("hold idle out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("hold idle in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("hold sub out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("hold sub result", result, 32'd0);
    checkOutput("hold sub zero", {31'd0, zero}, 32'd1);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checkOutput("hold no extra out_valid", 32'(pulses), 32'd0);

    // MUL_BITS = 4 instance: same product, N+1 = 9 cycles.
    @(negedge clk);
    aluOp = 2'b10; f3 = 3'b000; f7 = 1'b0; m = 1'b1; op = 1'b1;
    a = 32'hFFFFFFFF; b = 32'd3; in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    lat = 0;
    busyReady = 1'b0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (in_ready4) busyReady = 1'b1;
      if (out_valid4) break;
    end
    checkOutput("mul4 latency", 32'(lat), 32'd9);
    checkOutput("mul4 result", result4, 32'hFFFFFFFD);
    checkOutput("mul4 in_ready busy", {31'd0, busyReady}, 32'd0);
    checkOutput("mul4 illegal", {31'd0, illegal4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
